// File: rtl/antares_buffered_dport_pkg.sv
// Shared encodings and formatting helpers for the buffered data port.
// The bypass option is selected with the ANTARES_SB_BYPASS_EN macro in the top.
package antares_buffered_dport_pkg;

  typedef enum logic [2:0] {
    ANTARES_DP_IDLE  = 3'd0,
    ANTARES_DP_STORE = 3'd1,
    ANTARES_DP_LOAD  = 3'd2,
    ANTARES_DP_LDONE = 3'd3,
    ANTARES_DP_ACK   = 3'd4
  } dp_state_e;

  typedef enum logic [1:0] {
    ANTARES_SZ_WORD = 2'd0,
    ANTARES_SZ_HALF = 2'd1,
    ANTARES_SZ_BYTE = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } st_fmt_t;

  function automatic acc_size_e acc_size(input logic is_byte, input logic is_half);
    if (is_byte)      return ANTARES_SZ_BYTE;
    else if (is_half) return ANTARES_SZ_HALF;
    else              return ANTARES_SZ_WORD;
  endfunction

  function automatic logic misaligned(input acc_size_e sz, input logic [1:0] lo);
    return (sz == ANTARES_SZ_WORD && lo != 2'b00) || (sz == ANTARES_SZ_HALF && lo[0]);
  endfunction

  // Replicate the datum across all lanes; the mask picks the live ones.
  function automatic st_fmt_t fmt_store(input acc_size_e sz, input logic [1:0] lo,
                                        input logic [31:0] d);
    st_fmt_t f;
    case (sz)
      ANTARES_SZ_BYTE: begin f.data = {4{d[7:0]}};  f.mask = 4'b0001 << lo; end
      ANTARES_SZ_HALF: begin f.data = {2{d[15:0]}}; f.mask = lo[1] ? 4'b1100 : 4'b0011; end
      default:         begin f.data = d;            f.mask = 4'b1111; end
    endcase
    return f;
  endfunction

  function automatic logic [31:0] ld_extend(input acc_size_e sz, input logic [1:0] lo,
                                            input logic sgn, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      ANTARES_SZ_BYTE: return {{24{sgn & b[7]}}, b};
      ANTARES_SZ_HALF: return {{16{sgn & h[15]}}, h};
      default:         return w;
    endcase
  endfunction

endpackage

// File: rtl/antares_buffered_dport_if.sv
// Data-port bus: 4-phase request/ready handshake with byte write enables.
interface antares_buffered_dport_if;
  logic [31:0] dport_address;
  logic [31:0] dport_data_o;
  logic [3:0]  dport_wr;
  logic        dport_enable;
  logic [31:0] dport_data_i;
  logic        dport_ready;
  logic        dport_error;

  modport master (output dport_address, dport_data_o, dport_wr, dport_enable,
                  input  dport_data_i, dport_ready, dport_error);
  modport slave  (input  dport_address, dport_data_o, dport_wr, dport_enable,
                  output dport_data_i, dport_ready, dport_error);
endinterface

// File: rtl/antares_buffered_dport_store_buffer.sv
// Posted-store FIFO: word address, lane-formatted data and byte mask per entry,
// plus a parallel word-address match against all live entries.
module antares_buffered_dport_store_buffer
  import antares_buffered_dport_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  sb_entry_t   push_entry,
  input  logic        pop,
  input  logic [29:0] match_addr,
  output logic        full,
  output logic        empty,
  output sb_entry_t   head,
  output logic        match
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]             wr_ptr, rd_ptr;
  logic [DEPTH-1:0]        vld_q;
  sb_entry_t [DEPTH-1:0]   mem_q;
  logic [DEPTH-1:0]        hit;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem_q[rd_ptr[AW-1:0]];

  // Push after pop so a full-buffer push into the slot being retired stays live.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld_q  <= '0;
    end else begin
      if (pop) begin
        rd_ptr                 <= rd_ptr + 1'b1;
        vld_q[rd_ptr[AW-1:0]]  <= 1'b0;
      end
      if (push) begin
        wr_ptr                 <= wr_ptr + 1'b1;
        vld_q[wr_ptr[AW-1:0]]  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr[AW-1:0]] <= push_entry;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign hit[i] = vld_q[i] && (mem_q[i].addr == match_addr);
  end

  assign match = |hit;

endmodule

// File: rtl/antares_buffered_dport.sv
// MEM-stage data port with posted store buffer, 4-phase port FSM and bus timeout.
// Define ANTARES_SB_BYPASS_EN to let non-conflicting loads overtake buffered stores.
module antares_buffered_dport
  import antares_buffered_dport_pkg::*;
#(
  parameter int SB_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_i,
  input  logic        dmem_halfword,
  input  logic        dmem_byte,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic        dmem_sign_extend,
  input  logic        exception_ready,
  input  logic        sb_drain,
  output logic [31:0] dmem_data_o,
  output logic        dmem_request_stall,
  output logic        exc_address_l_mem,
  output logic        exc_address_s_mem,
  output logic        exc_bus_error,
  output logic        sb_error,
  output logic        sb_empty,
  antares_buffered_dport_if.master dport
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  dp_state_e   state_q, state_d;
  acc_size_e   size;
  st_fmt_t     st_fmt;
  sb_entry_t   sb_head;
  logic        mis, st_ok, ld_ok, ld_go;
  logic        sb_full, sb_buf_empty, sb_match, push, pop;
  logic        port_en, to_hit, bus_done, bus_fail;
  logic [CW-1:0] to_cnt_q;
  logic [31:0] ld_data_q;
  logic        ld_err_q, sb_error_q;

  assign size   = acc_size(dmem_byte, dmem_halfword);
  assign mis    = misaligned(size, dmem_address[1:0]);
  assign st_fmt = fmt_store(size, dmem_address[1:0], dmem_data_i);

  assign exc_address_l_mem = dmem_read  & mis;
  assign exc_address_s_mem = dmem_write & mis;
  assign st_ok = dmem_write & ~mis & ~exception_ready;
  assign ld_ok = dmem_read  & ~mis & ~exception_ready;

  // Timeout masquerades as an error unless ready lands in the same cycle.
  assign to_hit   = (TIMEOUT_CYCLES != 0) && port_en && (to_cnt_q == CW'(TIMEOUT_CYCLES));
  assign bus_done = dport.dport_ready | dport.dport_error | to_hit;
  assign bus_fail = dport.dport_error | (to_hit & ~dport.dport_ready);

  assign pop  = (state_q == ANTARES_DP_STORE) && bus_done;
  assign push = st_ok && (!sb_full || pop);

  antares_buffered_dport_store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry ('{addr: dmem_address[31:2], data: st_fmt.data, mask: st_fmt.mask}),
    .pop        (pop),
    .match_addr (dmem_address[31:2]),
    .full       (sb_full),
    .empty      (sb_buf_empty),
    .head       (sb_head),
    .match      (sb_match)
  );

`ifdef ANTARES_SB_BYPASS_EN
  assign ld_go = ld_ok && (sb_buf_empty || !sb_match);
`else
  logic sb_match_unused;
  assign sb_match_unused = sb_match;
  assign ld_go = ld_ok && sb_buf_empty;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ANTARES_DP_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ANTARES_DP_IDLE: begin
        if (ld_go)              state_d = ANTARES_DP_LOAD;
        else if (!sb_buf_empty) state_d = ANTARES_DP_STORE;
      end
      ANTARES_DP_STORE: if (bus_done) state_d = ANTARES_DP_ACK;
      ANTARES_DP_LOAD:  if (bus_done) state_d = ANTARES_DP_LDONE;
      ANTARES_DP_LDONE: state_d = ANTARES_DP_ACK;
      ANTARES_DP_ACK:   state_d = ANTARES_DP_IDLE;
      default:          state_d = ANTARES_DP_IDLE;
    endcase
  end

  always_comb begin
    port_en             = 1'b0;
    dport.dport_wr      = 4'b0000;
    dport.dport_address = dmem_address;
    dport.dport_data_o  = '0;
    exc_bus_error       = 1'b0;
    unique case (state_q)
      ANTARES_DP_STORE: begin
        port_en             = 1'b1;
        dport.dport_wr      = sb_head.mask;
        dport.dport_address = {sb_head.addr, 2'b00};
        dport.dport_data_o  = sb_head.data;
      end
      ANTARES_DP_LOAD:  port_en       = 1'b1;
      ANTARES_DP_LDONE: exc_bus_error = ld_err_q;
      default: ;
    endcase
  end

  assign dport.dport_enable = port_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q   <= '0;
      ld_data_q  <= '0;
      ld_err_q   <= 1'b0;
      sb_error_q <= 1'b0;
    end else begin
      if (state_q == ANTARES_DP_IDLE) to_cnt_q <= '0;
      else if (port_en)               to_cnt_q <= to_cnt_q + CW'(1);
      if (state_q == ANTARES_DP_LOAD && bus_done) begin
        ld_err_q  <= bus_fail;
        ld_data_q <= bus_fail ? 32'd0
                              : ld_extend(size, dmem_address[1:0], dmem_sign_extend,
                                          dport.dport_data_i);
      end
      if (pop && bus_fail) sb_error_q <= 1'b1;
    end
  end

  assign dmem_data_o = ld_data_q;
  assign sb_error    = sb_error_q;
  assign sb_empty    = sb_buf_empty && (state_q == ANTARES_DP_IDLE);

  // A load holds the pipeline until its LDONE cycle hands over the result.
  assign dmem_request_stall = (ld_ok && state_q != ANTARES_DP_LDONE)
                            || (st_ok && sb_full && !pop)
                            || (sb_drain && !sb_empty);

endmodule

// File: tb/tb_antares_buffered_dport.sv
// Directed bench for antares_buffered_dport (SB_DEPTH=4, TIMEOUT_CYCLES=8).
module tb_antares_buffered_dport;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmem_address, dmem_data_i, dmem_data_o;
  logic        dmem_halfword, dmem_byte, dmem_read, dmem_write, dmem_sign_extend;
  logic        exception_ready, sb_drain;
  logic        dmem_request_stall, exc_address_l_mem, exc_address_s_mem;
  logic        exc_bus_error, sb_error, sb_empty;
  int          errs = 0;
  int          checks = 0;

  antares_buffered_dport_if dp ();

  antares_buffered_dport #(.SB_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .dmem_address       (dmem_address),
    .dmem_data_i        (dmem_data_i),
    .dmem_halfword      (dmem_halfword),
    .dmem_byte          (dmem_byte),
    .dmem_read          (dmem_read),
    .dmem_write         (dmem_write),
    .dmem_sign_extend   (dmem_sign_extend),
    .exception_ready    (exception_ready),
    .sb_drain           (sb_drain),
    .dmem_data_o        (dmem_data_o),
    .dmem_request_stall (dmem_request_stall),
    .exc_address_l_mem  (exc_address_l_mem),
    .exc_address_s_mem  (exc_address_s_mem),
    .exc_bus_error      (exc_bus_error),
    .sb_error           (sb_error),
    .sb_empty           (sb_empty),
    .dport              (dp.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (dp.dport_enable !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".en"}, {31'd0, dp.dport_enable}, 32'd1);
  endtask

  task automatic ack_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, input int dly);
    wait_en(tag);
    chk({tag, ".addr"}, dp.dport_address, a);
    chk({tag, ".data"}, dp.dport_data_o, d);
    chk({tag, ".wr"}, {28'd0, dp.dport_wr}, {28'd0, m});
    repeat (dly) @(negedge clk);
    dp.dport_ready = 1'b1;
    @(negedge clk);
    dp.dport_ready = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
    dmem_address = a; dmem_data_i = d; dmem_byte = b; dmem_halfword = h;
    dmem_write = 1'b1;
  endtask

  task automatic load_op(input string tag, input logic [31:0] a, input logic b, input logic h,
                         input logic s, input logic [31:0] din, input logic [31:0] exp);
    dmem_address = a; dmem_byte = b; dmem_halfword = h; dmem_sign_extend = s;
    dmem_read = 1'b1;
    wait_en(tag);
    chk({tag, ".wr"}, {28'd0, dp.dport_wr}, 32'd0);
    chk({tag, ".addr"}, dp.dport_address, a);
    dp.dport_data_i = din;
    dp.dport_ready  = 1'b1;
    @(negedge clk);
    dp.dport_ready = 1'b0;
    #1;
    chk({tag, ".stall"}, {31'd0, dmem_request_stall}, 32'd0);
    chk({tag, ".data"}, dmem_data_o, exp);
    chk({tag, ".berr"}, {31'd0, exc_bus_error}, 32'd0);
    dmem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    dmem_address = '0; dmem_data_i = '0; dmem_halfword = 0; dmem_byte = 0;
    dmem_read = 0; dmem_write = 0; dmem_sign_extend = 0; exception_ready = 0; sb_drain = 0;
    dp.dport_data_i = '0; dp.dport_ready = 0; dp.dport_error = 0;
    repeat (2) @(negedge clk);
    chk("rst.en",    {31'd0, dp.dport_enable},     32'd0);
    chk("rst.wr",    {28'd0, dp.dport_wr},         32'd0);
    chk("rst.stall", {31'd0, dmem_request_stall},  32'd0);
    chk("rst.sberr", {31'd0, sb_error},            32'd0);
    chk("rst.empty", {31'd0, sb_empty},            32'd1);
    chk("rst.data",  dmem_data_o,                  32'd0);
    chk("rst.berr",  {31'd0, exc_bus_error},       32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Store word, then SYNC with ready two cycles late
    store(32'h100, 32'hDEADBEEF, 0, 0);
    #1 chk("sw.stall", {31'd0, dmem_request_stall}, 32'd0);
    @(negedge clk);
    dmem_write = 0; sb_drain = 1;
    #1 chk("sync.stall", {31'd0, dmem_request_stall}, 32'd1);
    ack_store("sw", 32'h100, 32'hDEADBEEF, 4'b1111, 2);
    chk("sw.ack_en", {31'd0, dp.dport_enable}, 32'd0);
    @(negedge clk);
    chk("sync.empty", {31'd0, sb_empty}, 32'd1);
    chk("sync.stall0", {31'd0, dmem_request_stall}, 32'd0);
    sb_drain = 0;

    // Five stores into a four-deep buffer, port not ready
    for (int k = 1; k <= 4; k++) begin
      store(32'h10 + 32'(4 * (k - 1)), 32'h11111111 * k, 0, 0);
      #1 chk($sformatf("fill%0d.stall", k), {31'd0, dmem_request_stall}, 32'd0);
      @(negedge clk);
    end
    store(32'h20, 32'h55555555, 0, 0);
    #1 chk("fill5.stall", {31'd0, dmem_request_stall}, 32'd1);
    wait_en("fill.head");
    chk("fill.head.addr", dp.dport_address, 32'h10);
    chk("fill.head.data", dp.dport_data_o, 32'h11111111);
    dp.dport_ready = 1'b1;
    #1 chk("fill5.retire_stall", {31'd0, dmem_request_stall}, 32'd0);
    @(negedge clk);
    dp.dport_ready = 1'b0; dmem_write = 0;
    for (int k = 2; k <= 5; k++)
      ack_store($sformatf("drain%0d", k), 32'h10 + 32'(4 * (k - 1)), 32'h11111111 * k,
                4'b1111, 0);
    @(negedge clk);
    chk("drain.empty", {31'd0, sb_empty}, 32'd1);

    // Store byte then signed byte load to the same address
    store(32'h203, 32'h12345680, 1, 0);
    @(negedge clk);
    dmem_write = 0; dmem_address = 32'h203; dmem_byte = 1; dmem_sign_extend = 1; dmem_read = 1;
    #1 chk("lb.wait_stall", {31'd0, dmem_request_stall}, 32'd1);
    ack_store("sb", 32'h200, 32'h80808080, 4'b1000, 0);
    load_op("lb", 32'h203, 1, 0, 1, 32'h80563412, 32'hFFFFFF80);
    load_op("lhu", 32'h202, 0, 1, 0, 32'h80563412, 32'h00008056);
    load_op("lh", 32'h202, 0, 1, 1, 32'h80563412, 32'hFFFF8056);
    load_op("lbu", 32'h201, 1, 0, 0, 32'h80563412, 32'h00000034);
    load_op("lw", 32'h204, 0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D);

    // Load timeout: nine LOAD cycles, error pulse in LDONE
    dmem_address = 32'h300; dmem_byte = 0; dmem_halfword = 0; dmem_read = 1;
    repeat (9) @(negedge clk);
    #1 chk("to.berr_early", {31'd0, exc_bus_error}, 32'd0);
    chk("to.stall_early", {31'd0, dmem_request_stall}, 32'd1);
    @(negedge clk);
    #1 chk("to.berr", {31'd0, exc_bus_error}, 32'd1);
    chk("to.data", dmem_data_o, 32'd0);
    chk("to.stall", {31'd0, dmem_request_stall}, 32'd0);
    dmem_read = 0;
    @(negedge clk);
    chk("to.pulse", {31'd0, exc_bus_error}, 32'd0);
    @(negedge clk);

    // Misaligned accesses are flagged and never enqueued
    store(32'h101, 32'h0000BEEF, 0, 1);
    #1 chk("sh.exc_s", {31'd0, exc_address_s_mem}, 32'd1);
    chk("sh.exc_l", {31'd0, exc_address_l_mem}, 32'd0);
    @(negedge clk);
    dmem_write = 0; dmem_halfword = 0; dmem_address = 32'h102; dmem_read = 1;
    #1 chk("lw.exc_l", {31'd0, exc_address_l_mem}, 32'd1);
    chk("lw.mis_stall", {31'd0, dmem_request_stall}, 32'd0);
    @(negedge clk);
    dmem_read = 0;
    chk("sh.no_en", {31'd0, dp.dport_enable}, 32'd0);
    chk("sh.empty", {31'd0, sb_empty}, 32'd1);

    // Flushed store is dropped
    store(32'h500, 32'h01020304, 0, 0);
    exception_ready = 1;
    @(negedge clk);
    dmem_write = 0; exception_ready = 0;
    @(negedge clk);
    chk("flush.no_en", {31'd0, dp.dport_enable}, 32'd0);
    chk("flush.empty", {31'd0, sb_empty}, 32'd1);

    // Store timeout becomes a sticky imprecise error
    store(32'h700, 32'h77777777, 0, 0);
    @(negedge clk);
    dmem_write = 0;
    repeat (11) @(negedge clk);
    chk("sto.sberr", {31'd0, sb_error}, 32'd1);
    chk("sto.empty", {31'd0, sb_empty}, 32'd1);

    // Reset in the middle of a store
    store(32'h600, 32'h66666666, 0, 0);
    @(negedge clk);
    dmem_write = 0;
    wait_en("rstmid");
    rst = 1'b0;
    #1 chk("rstmid.en", {31'd0, dp.dport_enable}, 32'd0);
    chk("rstmid.empty", {31'd0, sb_empty}, 32'd1);
    chk("rstmid.sberr", {31'd0, sb_error}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid.lost", {31'd0, dp.dport_enable}, 32'd0);

`ifdef ANTARES_SB_BYPASS_EN
    store(32'h400, 32'hAAAA0001, 0, 0);
    @(negedge clk);
    dmem_write = 0;
    load_op("byp.lw500", 32'h500, 0, 0, 0, 32'h00000055, 32'h00000055);
    ack_store("byp.st400", 32'h400, 32'hAAAA0001, 4'b1111, 0);
    @(negedge clk);
    store(32'h400, 32'hAAAA0002, 0, 0);
    @(negedge clk);
    dmem_write = 0; dmem_address = 32'h400; dmem_read = 1;
    ack_store("byp.hold", 32'h400, 32'hAAAA0002, 4'b1111, 0);
    load_op("byp.lw400", 32'h400, 0, 0, 0, 32'hAAAA0002, 32'hAAAA0002);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
endmodule
